// File: rtl/bsg_mesh_router_out_sched.sv
// bsg_mesh_router_out_sched: round-robin credit-based output scheduler with drain handshake; optional starvation guard via BSG_MESH_OUT_SCHED_STARVE_GUARD_EN
module bsg_mesh_router_out_sched #(
  parameter int width_p   = 16,
  parameter int dirs_p    = 5,
  parameter int credits_p = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [dirs_p-1:0]         v_i,
  input  logic [dirs_p*width_p-1:0] data_i,
  output logic [dirs_p-1:0]         yumi_o,
  output logic                      v_o,
  output logic [width_p-1:0]        data_o,
  input  logic                      credit_i,
  input  logic                      drain_i,
  output logic                      drained_o,
  output logic                      credit_err_o
);
  localparam int cw = $clog2(credits_p + 1);
  localparam int pw = (dirs_p > 1) ? $clog2(dirs_p) : 1;
  localparam logic [pw:0] dirs_w = (pw + 1)'(dirs_p);
  localparam logic [cw-1:0] credits_w = cw'(credits_p);
  typedef enum logic [1:0] {RUN, DRAIN, DRAINED} state_e;
  state_e state_r, state_n;
  logic [cw-1:0] credits_r, credits_n;
  logic [pw-1:0] rr_r, rr_idx, sel_idx;
  logic [pw:0] k;
  logic found, grant, full;
  // first requester at or after the rr pointer, wrapping around
  always_comb begin
    rr_idx = '0;
    found = 1'b0;
    k = '0;
    for (int i = 0; i < dirs_p; i++) begin
      k = {1'b0, rr_r} + (pw + 1)'(i);
      k = (k >= dirs_w) ? k - dirs_w : k;
      if (!found && v_i[k]) begin
        found = 1'b1;
        rr_idx = k[pw-1:0];
      end
    end
  end
`ifdef BSG_MESH_OUT_SCHED_STARVE_GUARD_EN
  logic [3:0] wait_r [dirs_p];
  logic starve;
  logic [pw-1:0] starve_idx;
  // lowest-index saturated waiter overrides round-robin
  always_comb begin
    starve = 1'b0;
    starve_idx = '0;
    for (int i = dirs_p - 1; i >= 0; i--) begin
      if (v_i[i] && wait_r[i] == 4'hf) begin
        starve = 1'b1;
        starve_idx = pw'(i);
      end
    end
  end
  assign sel_idx = starve ? starve_idx : rr_idx;
  // per-input wait counters: count ungranted cycles, clear on grant or idle
  always_ff @(posedge clk) begin
    for (int i = 0; i < dirs_p; i++)
      wait_r[i] <= (reset || !v_i[i] || yumi_o[i]) ? 4'h0 : (wait_r[i] == 4'hf) ? 4'hf : wait_r[i] + 4'h1;
  end
`else
  assign sel_idx = rr_idx;
`endif
  assign full = credits_r == credits_w;
  assign grant = (state_r == RUN) && !drain_i && (credits_r != '0) && found;
  assign yumi_o = grant ? {{(dirs_p-1){1'b0}}, 1'b1} << sel_idx : '0;
  assign drained_o = (state_r == DRAINED) && drain_i;
  // credit bookkeeping and drain state transitions
  always_comb begin
    credits_n = (grant && !credit_i) ? credits_r - 1'b1
              : (!grant && credit_i && !full) ? credits_r + 1'b1
              : credits_r;
    state_n = (state_r == RUN) ? (drain_i ? DRAIN : RUN)
            : !drain_i ? RUN
            : (state_r == DRAIN && credits_n == credits_w && !v_o) ? DRAINED
            : state_r;
  end
  // state, credits, rr pointer and the registered output flit
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      credits_r <= credits_w;
      rr_r <= '0;
      v_o <= 1'b0;
      data_o <= '0;
      credit_err_o <= 1'b0;
    end else begin
      state_r <= state_n;
      credits_r <= credits_n;
      v_o <= grant;
      if (grant) begin
        data_o <= data_i[sel_idx*width_p +: width_p];
        rr_r <= (sel_idx == pw'(dirs_p - 1)) ? '0 : sel_idx + 1'b1;
      end
      if (credit_i && full) credit_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bsg_mesh_router_out_sched.sv
// tb_bsg_mesh_router_out_sched: scoreboard bench for the output scheduler against a cycle model
module tb_bsg_mesh_router_out_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] v_i = '0;
  logic [79:0] data_i = '0;
  logic [4:0] yumi_o;
  logic v_o;
  logic [15:0] data_o;
  logic credit_i = 1'b0;
  logic drain_i = 1'b0;
  logic drained_o;
  logic credit_err_o;
  int n_checks = 0;
  int n_errors = 0;
  int cnum = 0;
  int m_state, m_cred, m_rr;
  logic m_err, m_v, vh1, vh2;
  logic [15:0] m_data;
  logic [15:0] q[$];

  bsg_mesh_router_out_sched #(.width_p(16), .dirs_p(5), .credits_p(4)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .data_i(data_i), .yumi_o(yumi_o),
    .v_o(v_o), .data_o(data_o), .credit_i(credit_i), .drain_i(drain_i),
    .drained_o(drained_o), .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cred = 4; m_rr = 0; m_err = 0; m_v = 0; vh1 = 0; vh2 = 0; m_data = '0;
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; v_i = '0; credit_i = 1'b0; drain_i = 1'b0;
    @(negedge clk);
    #1;
    check("rst_v_o", v_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_drained_o", drained_o, 0);
    check("rst_credit_err_o", credit_err_o, 0);
    reset = 1'b0;
    model_reset();
  endtask

  // cmode 0: credit_i = cr; 1: credit_i = v_o delayed 1 cycle; 2: delayed 2 cycles
  task automatic cyc(input logic [4:0] v, input int cmode, input logic cr, input logic dr);
    logic c, g;
    logic [4:0] ey;
    int gi, cn;
    @(negedge clk);
    c = (cmode == 1) ? vh1 : (cmode == 2) ? vh2 : cr;
    v_i = v; credit_i = c; drain_i = dr;
    for (int k = 0; k < 5; k++) data_i[k*16 +: 16] = 16'(k * 4096 + cnum);
    cnum++;
    #1;
    check("v_o", v_o, m_v);
    if (v_o) begin
      if (q.size() == 0) check("sb_underflow", q.size(), 1);
      else check("data_o", data_o, q.pop_front());
    end
    check("data_hold", data_o, m_data);
    check("drained_o", drained_o, m_state == 2 && dr);
    check("credit_err_o", credit_err_o, m_err);
    g = m_state == 0 && !dr && m_cred > 0 && v != 0;
    gi = 0;
    if (g) begin
      for (int i = 4; i >= 0; i--) if (v[(m_rr + i) % 5]) gi = (m_rr + i) % 5;
    end
    ey = g ? 5'(1 << gi) : 5'd0;
    check("yumi_o", yumi_o, ey);
    if (g) begin
      q.push_back(data_i[gi*16 +: 16]);
      m_data = data_i[gi*16 +: 16];
      m_rr = (gi + 1) % 5;
    end
    if (c && m_cred == 4) m_err = 1;
    cn = m_cred;
    if (g && !c) cn--;
    else if (!g && c && m_cred < 4) cn++;
    m_state = (m_state == 0) ? (dr ? 1 : 0) : !dr ? 0 : (m_state == 1 && cn == 4) ? 2 : m_state;
    m_cred = cn;
    vh2 = vh1; vh1 = m_v; m_v = g;
  endtask

  initial begin
    model_reset();
    do_reset();
    repeat (2) cyc(5'b00000, 0, 0, 0);
    repeat (12) cyc(5'b00010, 1, 0, 0);
    repeat (3) cyc(5'b00000, 1, 0, 0);
    repeat (15) cyc(5'b11111, 2, 0, 0);
    repeat (4) cyc(5'b00000, 2, 0, 0);
    repeat (6) cyc(5'b11111, 0, 0, 0);
    cyc(5'b11111, 0, 1, 0);
    cyc(5'b11111, 0, 0, 0);
    cyc(5'b11111, 0, 0, 0);
    cyc(5'b00000, 0, 1, 0);
    cyc(5'b11111, 0, 1, 0);
    cyc(5'b11111, 0, 0, 0);
    cyc(5'b11111, 0, 0, 0);
    repeat (4) cyc(5'b00000, 0, 1, 0);
    cyc(5'b00000, 0, 1, 0);
    repeat (6) cyc(5'b11111, 0, 0, 0);
    repeat (4) cyc(5'b00000, 0, 1, 0);
    repeat (3) cyc(5'b11111, 0, 0, 0);
    cyc(5'b11111, 0, 0, 1);
    repeat (3) cyc(5'b11111, 0, 1, 1);
    repeat (2) cyc(5'b11111, 0, 0, 1);
    cyc(5'b11111, 0, 0, 0);
    repeat (2) cyc(5'b11111, 0, 0, 0);
    do_reset();
    repeat (4) cyc(5'b11111, 0, 0, 0);
    cyc(5'b00000, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
